// File: rtl/uart_pkt_rx.sv
// Oversampled UART packet receiver. A packet is one start bit, PKT_BITS data bits
// (LSB first) and one stop bit. Reception is only armed after a full idle period.
//   state     | meaning
//   IDLE_WAIT | counting line-high clocks until the idle period is met
//   ARMED     | idle met; waiting for a start-bit falling edge
//   START     | validating the start bit
//   READING   | shifting in data bits
//   STOP      | sampling the stop bit and delivering the packet
module uart_pkt_rx #(
  parameter int unsigned CLK_HZ       = 65_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned SAMP_PER_BIT = 16,
  parameter int unsigned PKT_BITS     = 162,
  parameter int unsigned IDLE_NS      = 20_000_000
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                sig_in,
  input  logic                ack_in,
  output logic [PKT_BITS-1:0] data_out,
  output logic                valid_out,
  output logic                err_out,
  output logic                ovf_out,
  output logic                busy_out
);

  localparam int unsigned CPS      = CLK_HZ / (SAMP_PER_BIT * BAUD_RATE);
  localparam int unsigned BIT_CLKS = SAMP_PER_BIT * CPS;
  localparam longint unsigned IDLE_CLKS =
    (64'(IDLE_NS) * 64'(CLK_HZ)) / 64'd1_000_000_000;

  localparam int IDLE_W = (IDLE_CLKS > 1) ? $clog2(IDLE_CLKS) : 1;
  localparam int BC_W   = $clog2(BIT_CLKS);
  localparam int IDX_W  = (PKT_BITS > 1) ? $clog2(PKT_BITS) : 1;

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CLKS - 1);
  localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(BIT_CLKS - 1);
  localparam logic [BC_W-1:0]   SAMP_1    = BC_W'(BIT_CLKS / 2 - CPS);
  localparam logic [BC_W-1:0]   SAMP_2    = BC_W'(BIT_CLKS / 2);
  localparam logic [BC_W-1:0]   SAMP_3    = BC_W'(BIT_CLKS / 2 + CPS);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PKT_BITS - 1);

  typedef enum logic [2:0] {
    IDLE_WAIT = 3'd0,
    ARMED     = 3'd1,
    START     = 3'd2,
    READING   = 3'd3,
    STOP      = 3'd4
  } state_t;

  state_t              state_q,    state_d;
  logic                sync1_q,    sync1_d;
  logic                sync2_q,    sync2_d;
  logic                prev_q,     prev_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [BC_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [IDX_W-1:0]    bit_idx_q,  bit_idx_d;
  logic [1:0]          samp_q,     samp_d;
  logic [PKT_BITS-1:0] shift_q,    shift_d;
  logic [PKT_BITS-1:0] data_q,     data_d;
  logic                valid_q,    valid_d;
  logic                err_q,      err_d;
  logic                ovf_q,      ovf_d;

  logic            sync;
  logic            fall;
  logic            maj;
  logic            pkt_done;
  logic [BC_W-1:0] bit_cnt_adv;

  always_comb begin
    state_d    = state_q;
    sync1_d    = sig_in;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    idle_cnt_d = idle_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    pkt_done   = 1'b0;

    sync        = sync2_q;
    fall        = prev_q & ~sync;
    maj         = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync) | (samp_q[1] & sync);
    bit_cnt_adv = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;

    if (bit_cnt_q == SAMP_1) samp_d[0] = sync;
    if (bit_cnt_q == SAMP_2) samp_d[1] = sync;

    case (state_q)
      IDLE_WAIT: begin
        bit_cnt_d = '0;
        if (!sync) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          idle_cnt_d = '0;
          state_d    = ARMED;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      ARMED: begin
        idle_cnt_d = '0;
        bit_cnt_d  = '0;
        bit_idx_d  = '0;
        if (fall) state_d = START;
      end
      START: begin
        bit_cnt_d = bit_cnt_adv;
        if (bit_cnt_q == SAMP_3 && maj) begin
          bit_cnt_d = '0;
          state_d   = ARMED;
        end else if (bit_cnt_q == BIT_LAST) begin
          state_d = READING;
        end
      end
      READING: begin
        bit_cnt_d = bit_cnt_adv;
        if (bit_cnt_q == SAMP_3) begin
          // Right shift so the first-received bit ends up in bit 0.
          shift_d              = shift_q >> 1;
          shift_d[PKT_BITS-1] = maj;
        end
        if (bit_cnt_q == BIT_LAST) begin
          if (bit_idx_q == IDX_LAST) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        bit_cnt_d = bit_cnt_adv;
        if (bit_cnt_q == SAMP_3) begin
          pkt_done   = 1'b1;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
          state_d    = IDLE_WAIT;
        end
      end
      default: begin
        idle_cnt_d = '0;
        bit_cnt_d  = '0;
        state_d    = IDLE_WAIT;
      end
    endcase

    // A completing packet takes priority over a same-cycle acknowledge.
    if (pkt_done) begin
      data_d  = shift_q;
      err_d   = ~maj;
      valid_d = 1'b1;
      if (valid_q && !ack_in) ovf_d = 1'b1;
    end else if (valid_q && ack_in) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE_WAIT;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      idle_cnt_q <= '0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      idle_cnt_q <= idle_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign err_out   = err_q;
  assign ovf_out   = ovf_q;
  assign busy_out  = (state_q == START) || (state_q == READING) || (state_q == STOP);

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Bench for uart_pkt_rx: drives whole frames on the line and compares the
// delivered packet, handshake and overrun flags against a packet-level model.
module tb_uart_pkt_rx;

  localparam int BIT_CLKS = 160;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       sig_in = 1'b1;
  logic       ack_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       err_out;
  logic       ovf_out;
  logic       busy_out;

  always #5 clk_in = ~clk_in;

  uart_pkt_rx #(
    .CLK_HZ      (1_600_000),
    .BAUD_RATE   (10_000),
    .SAMP_PER_BIT(16),
    .PKT_BITS    (8),
    .IDLE_NS     (100_000)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sig_in   (sig_in),
    .ack_in   (ack_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .err_out  (err_out),
    .ovf_out  (ovf_out),
    .busy_out (busy_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Packet-level expectation of the output registers.
  logic       m_valid, m_err, m_ovf;
  logic [7:0] m_data;
  logic       any_valid = 1'b0;
  logic       any_busy  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      if (valid_out) any_valid = 1'b1;
      if (busy_out)  any_busy  = 1'b1;
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_ovf   = 1'b0;
    m_data  = 8'h00;
  endtask

  task automatic model_done(input logic [7:0] d, input logic stop);
    if (m_valid) m_ovf = 1'b1;
    m_data  = d;
    m_err   = ~stop;
    m_valid = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, valid_out, m_valid);
    chk({tag, ".data"},  data_out,  m_data);
    chk({tag, ".err"},   err_out,   m_err);
    chk({tag, ".ovf"},   ovf_out,   m_ovf);
  endtask

  task automatic do_reset(input int n);
    rst_in = 1'b1;
    tick(n);
    rst_in = 1'b0;
    model_clear();
  endtask

  // goff: -1 no glitch, -2 random mid-bit glitch, else fixed clock offset in each bit
  task automatic drive_bit(input logic b, input int goff);
    int g;
    g = (goff == -2) ? int'($urandom_range(120, 40)) : goff;
    for (int c = 0; c < BIT_CLKS; c++) begin
      sig_in = (c == g) ? ~b : b;
      tick(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int goff,
                            input logic chk_busy);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (chk_busy && i == 5) chk("busy_mid", busy_out, 1);
      drive_bit(bits[i], goff);
    end
    sig_in = 1'b1;
  endtask

  // 200 line-high clocks after a frame, optionally acknowledging mid-gap.
  task automatic post(input string tag, input logic do_ack);
    sig_in = 1'b1;
    tick(20);
    check_all(tag);
    if (do_ack) begin
      tick(10);
      ack_in = 1'b1;
      tick(1);
      ack_in = 1'b0;
      if (m_valid) begin
        m_valid = 1'b0;
        m_err   = 1'b0;
      end
      tick(169);
    end else begin
      tick(180);
    end
    check_all({tag, "_gap"});
    chk({tag, "_gap.busy"}, busy_out, 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       ack;
    int         goff;

    model_clear();
    sig_in = 1'b1;
    do_reset(5);
    check_all("reset");
    chk("reset.busy", busy_out, 0);
    tick(200);

    send_frame(8'hA5, 1'b1, -1, 1'b1);
    model_done(8'hA5, 1'b1);
    post("a5", 1'b1);

    // False start while armed: short low pulse, then a real frame with no re-idle.
    any_busy = 1'b0;
    sig_in = 1'b0;
    tick(20);
    sig_in = 1'b1;
    tick(130);
    chk("fstart.busy_seen", any_busy, 1);
    chk("fstart.busy_end", busy_out, 0);
    check_all("fstart");
    send_frame(8'h96, 1'b1, -1, 1'b1);
    model_done(8'h96, 1'b1);
    post("after_fstart", 1'b1);

    send_frame(8'h3C, 1'b0, -1, 1'b1);
    model_done(8'h3C, 1'b0);
    post("frame_err", 1'b1);

    send_frame(8'h11, 1'b1, -1, 1'b1);
    model_done(8'h11, 1'b1);
    post("ovf_first", 1'b0);
    send_frame(8'h22, 1'b1, -1, 1'b1);
    model_done(8'h22, 1'b1);
    post("ovf_second", 1'b0);

    do_reset(2);
    check_all("reset2");
    tick(200);
    send_frame(8'h5A, 1'b1, 81, 1'b1);
    model_done(8'h5A, 1'b1);
    post("glitch", 1'b0);

    // Reset during data bit 4, then a frame with no idle gap must be ignored.
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, -1);
    sig_in = 1'b1;
    tick(50);
    do_reset(1);
    check_all("midrst");
    chk("midrst.busy", busy_out, 0);
    any_valid = 1'b0;
    send_frame(8'h00, 1'b1, -1, 1'b0);
    tick(200);
    chk("midrst.no_valid", any_valid, 0);
    check_all("midrst_idle");
    send_frame(8'hC3, 1'b1, -1, 1'b1);
    model_done(8'hC3, 1'b1);
    post("after_rst", 1'b1);

    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      goff = ($urandom_range(1) == 1) ? -2 : -1;
      ack  = 1'($urandom_range(1));
      send_frame(d, stop, goff, 1'b1);
      model_done(d, stop);
      post($sformatf("rnd%0d", i), ack);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_pkt_rx.md
UART_PKT_RX -- requirements
Module: uart_pkt_rx

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter CLK_HZ, 65_000_000, clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, 9600, line bit rate.
REQ-003 The block SHALL have parameter SAMP_PER_BIT, 16, oversampling factor, legal values 4 or more; CPS = CLK_HZ/(SAMP_PER_BIT*BAUD_RATE) and BIT_CLKS = SAMP_PER_BIT*CPS, both integer-truncated.
REQ-004 The block SHALL have parameter PKT_BITS, 162, data bits per packet, legal range 1..1024.
REQ-005 The block SHALL have parameter IDLE_NS, 20_000_000, required line-high idle time in ns; IDLE_CLKS = IDLE_NS*CLK_HZ/1e9, computed in 64-bit arithmetic.

Ports (name, direction, width, meaning):
REQ-006 The block SHALL have port clk_in, input, 1, the single clock; all logic is posedge.
REQ-007 The block SHALL have port rst_in, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port sig_in, input, 1, asynchronous serial line, idle high.
REQ-009 The block SHALL have port ack_in, input, 1, consumer acknowledge.
REQ-010 The block SHALL have port data_out, output, PKT_BITS, last received packet; first-received bit is in bit 0.
REQ-011 The block SHALL have port valid_out, output, 1, packet available, held until acked.
REQ-012 The block SHALL have port err_out, output, 1, stop-bit error flag of the packet currently presented.
REQ-013 The block SHALL have port ovf_out, output, 1, sticky overrun flag.
REQ-014 The block SHALL have port busy_out, output, 1, high in START, READING and STOP.

Function
REQ-015 sig_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (sync).
REQ-016 The FSM SHALL have states IDLE_WAIT, ARMED, START, READING and STOP; unreachable encodings go to IDLE_WAIT.
REQ-017 IDLE_WAIT: counter increments while sync=1 and clears when sync=0; at count==IDLE_CLKS-1 with sync=1 the next state SHALL be ARMED.
REQ-018 ARMED: a falling edge of sync (previous 1, current 0) SHALL move to START with the bit counter at 0; falling edges outside ARMED SHALL be ignored.
REQ-019 Every bit decision SHALL be a 2-of-3 majority of sync taken at bit-counter values BIT_CLKS/2-CPS, BIT_CLKS/2 and BIT_CLKS/2+CPS.
REQ-020 START: if the start-bit majority is 1 (false start), the next state SHALL be ARMED; otherwise it SHALL be READING at bit-counter wrap (BIT_CLKS-1 -> 0).
REQ-021 READING: the bit counter SHALL wrap every BIT_CLKS clocks; each bit's majority SHALL be shifted into the MSB of a PKT_BITS shift register (right shift); after PKT_BITS bits the next state SHALL be STOP.
REQ-022 STOP: the stop-bit majority SHALL be sampled; at the decision cycle data_out <= shift register, err_out <= ~majority, valid_out <= 1, and the next state SHALL be IDLE_WAIT with the counter cleared.
REQ-023 Frame-error packets SHALL still be delivered.
REQ-024 Handshake: while valid_out=1, a cycle with ack_in=1 SHALL clear valid_out and err_out on the next edge; ack_in while valid_out=0 SHALL have no effect.
REQ-025 Overrun: if a packet completes while valid_out=1 and ack_in=0, data_out and err_out SHALL be overwritten and ovf_out SHALL be set and stay set until reset.
REQ-026 If a packet completes and ack_in=1 in the same cycle, the new packet SHALL win, valid_out SHALL stay 1, and ovf_out SHALL be unchanged.
REQ-027 data_out SHALL change only at packet completion or reset.

Reset
REQ-028 While rst_in=1 at an edge: state=IDLE_WAIT; all counters, the shift register and the synchronizer SHALL be 0; data_out=0, valid_out=0, err_out=0, ovf_out=0, busy_out=0.
REQ-029 Reset mid-packet SHALL discard the partial packet; a full IDLE_CLKS idle period SHALL be required before the next reception.

Verification (CLK_HZ=1_600_000, BAUD_RATE=10_000, SAMP_PER_BIT=16 -> CPS=10, BIT_CLKS=160; PKT_BITS=8, IDLE_NS=100_000 -> IDLE_CLKS=160)
REQ-030 Line high 200 clk, then start 0, data 0xA5 LSB-first, stop 1 -> data_out=8'hA5, valid_out=1, err_out=0, ovf_out=0; ack_in for 1 clk -> valid_out=0.
REQ-031 In ARMED, line low for 20 clk then high -> START then back to ARMED, busy_out pulses and returns to 0, valid_out=0.
REQ-032 Frame 0x3C with the stop bit driven 0 -> data_out=8'h3C, valid_out=1, err_out=1.
REQ-033 Frames 0x11 then 0x22 with no ack -> data_out=8'h22, valid_out=1, ovf_out=1.
REQ-034 A 1-clk inverted glitch at the mid sample of every bit of frame 0x5A -> data_out=8'h5A.
REQ-035 rst_in for 1 clk during data bit 4, then an immediate frame without an idle gap -> no valid_out, all outputs 0; the next frame after 160 idle clk is received correctly.
